// File: rtl/outport_uart_tx_pkg.sv
// Shared encodings for the output-port UART transmitter.
package outport_uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/outport_fifo.sv
// DEPTH x WIDTH synchronous FIFO with a registered occupancy count.
// Push is ignored when full and pop is ignored when empty; both may happen on one edge.
module outport_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q, level_d;
    logic             do_push, do_pop;

    assign full_o  = (level_q == FULL_LVL);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (level_q != '0);

    always_comb begin
        level_d = level_q;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/outport_uart_tx.sv
// Buffers 32-bit output-port words and sends each as 4 UART frames, LSB byte first.
// First start bit one edge after a write into an empty idle FIFO; writes while full are dropped and flagged.
module outport_uart_tx
    import outport_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    out_wr,
    input  logic [31:0]             out_data,
    output logic                    tx,
    output logic                    busy,
    output logic                    full,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  level
);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t          state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [31:0]     shreg_q, shreg_d;
    logic            tx_q, tx_d;
    logic            ovf_q, ovf_d;
    logic            pop;
    logic            baud_wrap;
    logic [31:0]     fifo_head;
    logic [$clog2(DEPTH):0] fifo_level;
    logic            fifo_full;

    outport_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (out_wr),
        .push_dat_i (out_data),
        .pop_i      (pop),
        .head_o     (fifo_head),
        .level_o    (fifo_level),
        .full_o     (fifo_full)
    );

    assign baud_wrap = (baud_q == BAUD_MAX);
    assign ovf_d     = ovf_q | (out_wr & fifo_full);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        if (state_q != ST_IDLE) baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (fifo_level != '0) begin
                    pop     = 1'b1;
                    shreg_d = fifo_head;
                    byte_d  = '0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_wrap) begin
                    bit_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                // The shifter always presents the current bit at [0], so after 8 shifts the next byte is in place.
                if (baud_wrap) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shreg_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (baud_wrap) begin
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 1'b1;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else if (fifo_level != '0) begin
                        pop     = 1'b1;
                        shreg_d = fifo_head;
                        byte_d  = '0;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = ovf_q;
    assign full     = fifo_full;
    assign level    = fifo_level;
    assign busy     = (state_q != ST_IDLE) | (fifo_level != '0);

endmodule

// File: tb/tb_outport_uart_tx.sv
// Directed bench for outport_uart_tx with CLKS_PER_BIT=4, DEPTH=4; a line monitor decodes frames.
module tb_outport_uart_tx;
    logic        clk = 1'b0;
    logic        rst;
    logic        out_wr;
    logic [31:0] out_data;
    logic        tx, busy, full, overflow;
    logic [2:0]  level;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] rx_bytes[$];
    int         start_cyc[$];
    bit         m_act = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_sh  = '0;

    outport_uart_tx #(.CLKS_PER_BIT(4), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .out_wr   (out_wr),
        .out_data (out_data),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Frame decoder: 4 samples per bit, data sampled mid-bit, stop bit checked mid-bit.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            m_act = 1'b0;
            m_cnt = 0;
        end else if (!m_act) begin
            if (tx === 1'b0) begin
                m_act = 1'b1;
                m_cnt = 0;
                start_cyc.push_back(cyc);
            end
        end else begin
            m_cnt++;
            if (m_cnt >= 6 && m_cnt <= 34 && ((m_cnt - 6) % 4) == 0) m_sh = {tx, m_sh[7:1]};
            if (m_cnt == 38) begin
                total++;
                if (tx !== 1'b1) begin
                    bad++;
                    $display("FAIL stop_bit: got tx=%b need 1 (frame %0d)", tx, start_cyc.size());
                end
                rx_bytes.push_back(m_sh);
                m_act = 1'b0;
            end
        end
    end

    task automatic wait_idle(output bit to);
        int guard;
        guard = 0;
        to = 1'b0;
        while (busy !== 1'b0) begin
            if (guard >= 6000) begin
                to = 1'b1;
                return;
            end
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic clear_mon();
        rx_bytes.delete();
        start_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0; out_wr = 1'b0; out_data = '0;
        #1 rst = 1'b1;
        #2;
        total++; if (tx !== 1'b1)       begin bad++; $display("FAIL reset_tx: got %b need 1", tx); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b need 0", busy); end
        total++; if (full !== 1'b0)     begin bad++; $display("FAIL reset_full: got %b need 0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b need 0", overflow); end
        total++; if (level !== 3'd0)    begin bad++; $display("FAIL reset_level: got %0d need 0", level); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        logic [7:0] exp[$];
        logic [31:0] w;
        bit to, ok;
        int n;
        w = 32'hA1B2C3D4;
        clear_mon();
        @(negedge clk); out_wr = 1'b1; out_data = w;
        @(posedge clk); #1;
        total++; if (tx !== 1'b1 || level !== 3'd1 || busy !== 1'b1) begin
            bad++; $display("FAIL single_after_write: got tx=%b level=%0d busy=%b need 1/1/1", tx, level, busy);
        end
        @(negedge clk); out_wr = 1'b0;
        @(posedge clk); #1;
        total++; if (tx !== 1'b0 || level !== 3'd0) begin
            bad++; $display("FAIL single_start: got tx=%b level=%0d need 0/0", tx, level);
        end
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL single_timeout: busy stuck at %b need 0", busy); end
        n = (start_cyc.size() > 0) ? cyc - start_cyc[0] : -1;
        total++; if (n != 160) begin bad++; $display("FAIL single_busy_len: got %0d need 160", n); end
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL single_idle_tx: got %b need 1", tx); end
        for (int b = 0; b < 4; b++) exp.push_back(w[8*b +: 8]);
        ok = (rx_bytes.size() == exp.size());
        for (int i = 0; i < exp.size() && ok; i++) if (rx_bytes[i] !== exp[i]) ok = 1'b0;
        total++; if (!ok) begin
            bad++; $display("FAIL single_bytes: got %0d bytes first=%h need D4 C3 B2 A1", rx_bytes.size(),
                            (rx_bytes.size() > 0) ? rx_bytes[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp[$];
        logic [31:0] w[2];
        bit to, ok;
        int n, gaps;
        w[0] = 32'h00000055; w[1] = 32'h000000AA;
        clear_mon();
        @(negedge clk); out_wr = 1'b1; out_data = w[0];
        @(negedge clk); out_data = w[1];
        @(negedge clk); out_wr = 1'b0;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL b2b_timeout: busy stuck at %b need 0", busy); end
        n = (start_cyc.size() > 0) ? cyc - start_cyc[0] : -1;
        total++; if (n != 320) begin bad++; $display("FAIL b2b_busy_len: got %0d need 320", n); end
        n = (start_cyc.size() == 8) ? start_cyc[4] - start_cyc[3] : -1;
        total++; if (n != 40) begin bad++; $display("FAIL b2b_word_gap: got %0d need 40 cycles frame4->5", n); end
        gaps = 0;
        for (int i = 0; i + 1 < start_cyc.size(); i++) if (start_cyc[i+1] - start_cyc[i] != 40) gaps++;
        total++; if (start_cyc.size() != 8 || gaps != 0) begin
            bad++; $display("FAIL b2b_frames: got %0d frames %0d gaps need 8 frames 0 gaps", start_cyc.size(), gaps);
        end
        for (int k = 0; k < 2; k++) for (int b = 0; b < 4; b++) exp.push_back(w[k][8*b +: 8]);
        ok = (rx_bytes.size() == exp.size());
        for (int i = 0; i < exp.size() && ok; i++) if (rx_bytes[i] !== exp[i]) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL b2b_bytes: got %0d bytes need 8 matching", rx_bytes.size()); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp[$];
        logic [31:0] w[6];
        bit to, ok;
        int n;
        for (int i = 0; i < 6; i++) w[i] = 32'h10203040 + i * 32'h01010101;
        clear_mon();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) begin
                total++; if (level !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
                    bad++; $display("FAIL ovf_full: got level=%0d full=%b ovf=%b need 4/1/0", level, full, overflow);
                end
            end
            out_wr = 1'b1; out_data = w[i];
        end
        @(negedge clk); out_wr = 1'b0;
        total++; if (overflow !== 1'b1 || level !== 3'd4) begin
            bad++; $display("FAIL ovf_drop: got ovf=%b level=%0d need 1/4", overflow, level);
        end
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL ovf_timeout: busy stuck at %b need 0", busy); end
        n = (start_cyc.size() > 0) ? cyc - start_cyc[0] : -1;
        total++; if (n != 800) begin bad++; $display("FAIL ovf_busy_len: got %0d need 800", n); end
        for (int k = 0; k < 5; k++) for (int b = 0; b < 4; b++) exp.push_back(w[k][8*b +: 8]);
        ok = (rx_bytes.size() == exp.size());
        for (int i = 0; i < exp.size() && ok; i++) if (rx_bytes[i] !== exp[i]) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL ovf_bytes: got %0d bytes need 20 matching words 0-4", rx_bytes.size()); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b need 1", overflow); end
    endtask

    task automatic test_reset_mid();
        int guard, lows;
        clear_mon();
        @(negedge clk); out_wr = 1'b1; out_data = 32'hDEADBEEF;
        @(negedge clk); out_data = 32'h01234567;
        @(negedge clk); out_data = 32'h89ABCDEF;
        @(negedge clk); out_wr = 1'b0;
        total++; if (level !== 3'd2) begin bad++; $display("FAIL rstmid_queued: got level=%0d need 2", level); end
        guard = 0;
        while ((start_cyc.size() == 0 || cyc < start_cyc[0] + 58) && guard < 200) begin
            @(negedge clk); guard++;
        end
        total++; if (guard >= 200) begin bad++; $display("FAIL rstmid_timeout: no frame start seen, tx=%b", tx); end
        #1 rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1)       begin bad++; $display("FAIL rstmid_tx: got %b need 1", tx); end
        total++; if (level !== 3'd0)    begin bad++; $display("FAIL rstmid_level: got %0d need 0", level); end
        total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rstmid_busy: got %b need 0", busy); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rstmid_overflow: got %b need 0", overflow); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_mon();
        lows = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        total++; if (lows != 0 || start_cyc.size() != 0) begin
            bad++; $display("FAIL rstmid_quiet: got %0d low samples %0d frames need 0/0", lows, start_cyc.size());
        end
    endtask

    task automatic test_push_pop();
        logic [7:0] exp[$];
        logic [31:0] w[3];
        bit to, ok;
        int guard, n;
        w[0] = 32'h5A5A0F0F; w[1] = 32'hC3C33C3C; w[2] = 32'h7E81FF00;
        clear_mon();
        @(negedge clk); out_wr = 1'b1; out_data = w[0];
        @(negedge clk); out_data = w[1];
        @(negedge clk); out_wr = 1'b0;
        guard = 0;
        while ((start_cyc.size() == 0 || cyc < start_cyc[0] + 159) && guard < 400) begin
            @(negedge clk); guard++;
        end
        total++; if (guard >= 400) begin bad++; $display("FAIL pp_timeout: did not reach last STOP, tx=%b", tx); end
        total++; if (level !== 3'd1 || tx !== 1'b1) begin
            bad++; $display("FAIL pp_pre: got level=%0d tx=%b need 1/1", level, tx);
        end
        out_wr = 1'b1; out_data = w[2];
        @(posedge clk); #1;
        total++; if (level !== 3'd1) begin bad++; $display("FAIL pp_level: got %0d need 1", level); end
        total++; if (tx !== 1'b0) begin bad++; $display("FAIL pp_start: got tx=%b need 0", tx); end
        @(negedge clk); out_wr = 1'b0;
        wait_idle(to);
        total++; if (to) begin bad++; $display("FAIL pp_idle_timeout: busy stuck at %b need 0", busy); end
        n = (start_cyc.size() > 0) ? cyc - start_cyc[0] : -1;
        total++; if (n != 480) begin bad++; $display("FAIL pp_busy_len: got %0d need 480", n); end
        for (int k = 0; k < 3; k++) for (int b = 0; b < 4; b++) exp.push_back(w[k][8*b +: 8]);
        ok = (rx_bytes.size() == exp.size());
        for (int i = 0; i < exp.size() && ok; i++) if (rx_bytes[i] !== exp[i]) ok = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL pp_bytes: got %0d bytes need 12 matching", rx_bytes.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_push_pop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
